// File: rtl/wave_capture_ctrl_if.sv
// rtl/wave_capture_ctrl_if.sv - sample stream, RAM write port and display handshake for wave_capture_ctrl
interface wave_capture_ctrl_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int OUT_WIDTH    = 8,
  parameter int ADDR_BITS    = 8
);
  logic                    new_sample_ready;
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    wave_display_idle;
  logic                    write_enable;
  logic [ADDR_BITS:0]      write_address;
  logic [OUT_WIDTH-1:0]    write_sample;
  logic                    read_index;

  modport master (
    input  new_sample_ready, sample_in, wave_display_idle,
    output write_enable, write_address, write_sample, read_index
  );

  modport slave (
    output new_sample_ready, sample_in, wave_display_idle,
    input  write_enable, write_address, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture_ctrl.sv
// rtl/wave_capture_ctrl.sv - zero-crossing triggered ping-pong waveform capture into a split RAM
module wave_capture_ctrl #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int OUT_WIDTH    = 8,
  parameter int ADDR_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  wave_capture_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] offset;
  logic                 prev_neg;
  logic                 sample_neg;
  logic                 rising;
  logic [OUT_WIDTH-1:0] sample_conv;
  logic                 sample_low_unused;

  // Offset-binary: top OUT_WIDTH bits of the sample with the sign bit flipped.
  assign sample_neg        = bus.sample_in[SAMPLE_WIDTH-1];
  assign sample_conv       = {~sample_neg, bus.sample_in[SAMPLE_WIDTH-2 -: OUT_WIDTH-1]};
  assign sample_low_unused = ^bus.sample_in[SAMPLE_WIDTH-OUT_WIDTH-1:0];
  assign rising            = prev_neg & ~sample_neg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_ARMED;
      offset            <= '0;
      prev_neg          <= 1'b0;
      bus.read_index    <= 1'b0;
      bus.write_enable  <= 1'b0;
      bus.write_address <= {1'b1, {ADDR_BITS{1'b0}}};
      bus.write_sample  <= '0;
    end else begin
      bus.write_enable <= 1'b0;
      if (bus.new_sample_ready) begin
        prev_neg <= sample_neg;
      end
      case (state)
        S_ARMED: begin
          if (bus.new_sample_ready && rising) begin
            bus.write_enable  <= 1'b1;
            bus.write_address <= {~bus.read_index, {ADDR_BITS{1'b0}}};
            bus.write_sample  <= sample_conv;
            offset            <= {{(ADDR_BITS-1){1'b0}}, 1'b1};
            state             <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (bus.new_sample_ready) begin
            bus.write_enable  <= 1'b1;
            bus.write_address <= {~bus.read_index, offset};
            bus.write_sample  <= sample_conv;
            if (offset == {ADDR_BITS{1'b1}}) begin
              offset <= '0;
              state  <= S_WAIT;
            end else begin
              offset <= offset + 1'b1;
            end
          end
        end
        S_WAIT: begin
          // The display half only flips here, so a window never straddles halves.
          if (bus.wave_display_idle) begin
            bus.read_index <= ~bus.read_index;
            state          <= S_ARMED;
          end
        end
        default: state <= S_ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// tb/tb_wave_capture_ctrl.sv - randomized and directed checks of wave_capture_ctrl against a window model
module tb_wave_capture_ctrl;
  localparam int SW = 16;
  localparam int OW = 8;
  localparam int AB = 8;
  localparam int N  = 1 << AB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wave_capture_ctrl_if #(.SAMPLE_WIDTH(SW), .OUT_WIDTH(OW), .ADDR_BITS(AB)) bus ();

  wave_capture_ctrl #(.SAMPLE_WIDTH(SW), .OUT_WIDTH(OW), .ADDR_BITS(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: samples captured in the current window (0 = waiting for a trigger, N = full).
  int m_captured = 0;
  int m_last     = 0;
  int m_ridx     = 0;
  int m_we       = 0;
  int m_addr     = N;
  int m_data     = 0;
  int dut_writes = 0;
  int base_writes;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic model_update(input logic rst, input logic stb, input logic [SW-1:0] smp,
                              input logic idle);
    int s;
    s = int'($signed(smp));
    if (rst) begin
      m_captured = 0;
      m_last     = 0;
      m_ridx     = 0;
      m_we       = 0;
      m_addr     = N;
      m_data     = 0;
      return;
    end
    m_we = 0;
    if (m_captured == N) begin
      if (idle) begin
        m_ridx     = 1 - m_ridx;
        m_captured = 0;
      end
    end else if (stb && (m_captured > 0 || (m_last < 0 && s >= 0))) begin
      m_we       = 1;
      m_addr     = (m_ridx == 1 ? 0 : N) + m_captured;
      m_data     = (s >>> (SW - OW)) + (1 << (OW - 1));
      m_captured = m_captured + 1;
    end
    if (stb) m_last = s;
  endtask

  task automatic step(input logic rst, input logic stb, input logic [SW-1:0] smp,
                      input logic idle);
    reset                 = rst;
    bus.new_sample_ready  = stb;
    bus.sample_in         = smp;
    bus.wave_display_idle = idle;
    @(posedge clk);
    model_update(rst, stb, smp, idle);
    @(negedge clk);
    check("write_enable", int'(bus.write_enable), m_we);
    check("write_address", int'(bus.write_address), m_addr);
    check("write_sample", int'(bus.write_sample), m_data);
    check("read_index", int'(bus.read_index), m_ridx);
    if (bus.write_enable) dut_writes++;
  endtask

  initial begin
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 16'h8000, 1'b1);
    check("reset_addr", int'(bus.write_address), 256);
    check("reset_we", int'(bus.write_enable), 0);

    // No trigger before a negative sample has been seen.
    dut_writes = 0;
    step(1'b0, 1'b1, 16'h0100, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 16'hFF00, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("no_early_write", dut_writes, 0);
    step(1'b0, 1'b1, 16'h0200, 1'b0);
    check("trigger_we", int'(bus.write_enable), 1);
    check("trigger_addr", int'(bus.write_address), 256);
    check("trigger_data", int'(bus.write_sample), 8'h82);

    for (int i = 0; i < N - 1; i++) begin
      step(1'b0, 1'b1, SW'(i << 8), 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
    end
    check("first_window_writes", dut_writes, N);
    check("last_addr", int'(bus.write_address), 511);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h8000, 1'b0);
    check("wait_no_writes", dut_writes, N);
    check("wait_read_index", int'(bus.read_index), 0);

    step(1'b0, 1'b0, '0, 1'b1);
    check("flip_read_index", int'(bus.read_index), 1);

    // Second window captured back-to-back into the lower half.
    base_writes = dut_writes;
    step(1'b0, 1'b1, 16'h8000, 1'b0);
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    check("lower_first_addr", int'(bus.write_address), 0);
    for (int i = 0; i < N - 1; i++) step(1'b0, 1'b1, SW'($urandom), 1'b0);
    check("b2b_writes", dut_writes - base_writes, N);
    check("b2b_last_addr", int'(bus.write_address), 255);

    // Strobe together with idle in WAIT: flip only, and prev becomes nonnegative.
    base_writes = dut_writes;
    step(1'b0, 1'b1, 16'hF000, 1'b0);
    step(1'b0, 1'b1, 16'h0500, 1'b1);
    check("coincide_read_index", int'(bus.read_index), 0);
    step(1'b0, 1'b1, 16'h0600, 1'b0);
    check("coincide_no_write", dut_writes - base_writes, 0);

    // Reset in the middle of a window.
    step(1'b0, 1'b1, 16'h9000, 1'b0);
    step(1'b0, 1'b1, 16'h1000, 1'b0);
    for (int i = 0; i < 99; i++) step(1'b0, 1'b1, SW'($urandom), 1'b0);
    step(1'b1, 1'b1, 16'h2000, 1'b0);
    check("midreset_we", int'(bus.write_enable), 0);
    check("midreset_addr", int'(bus.write_address), 256);
    check("midreset_ridx", int'(bus.read_index), 0);
    base_writes = dut_writes;
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    step(1'b0, 1'b1, 16'h0234, 1'b0);
    check("midreset_no_retrigger", dut_writes - base_writes, 0);

    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 2) != 0), SW'($urandom),
           ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
Sequences sample writes into the 1-write/2-read waveform RAM for the wave display. Watches the audio sample stream and arms on a rising zero crossing. Captures a fixed-length window into the half of the RAM the display is not reading, then flips halves (ping-pong) once the display reports idle. Sits between the codec sample path and the RAM write port; read_index goes to the display's read-address MSB.

Parameters:
SAMPLE_WIDTH, 16, width of signed two's-complement input sample
OUT_WIDTH, 8, width of stored RAM word (offset-binary)
ADDR_BITS, 8, address bits per half; window length = 2**ADDR_BITS samples

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
new_sample_ready  input  1  one-cycle strobe; sample_in valid this cycle
sample_in  input  SAMPLE_WIDTH  signed audio sample
wave_display_idle  input  1  high while display is not reading RAM (blanking)
write_enable  output  1  RAM write strobe, registered
write_address  output  ADDR_BITS+1  RAM write address = {~read_index, offset}, registered
write_sample  output  OUT_WIDTH  RAM write data, registered
read_index  output  1  half currently owned by display; write half is its complement

Behaviour:
- Reset (clk edge with reset=1): state=ARMED, offset=0, prev_sample=0, read_index=0, write_enable=0, write_address={1'b1, 0} (decimal 256 at default), write_sample=0. Reset overrides all other inputs that cycle. Mid-window reset abandons the window with no further writes.
- Data conversion: write_sample = sample_in[SAMPLE_WIDTH-1 -: OUT_WIDTH] with MSB inverted, e.g. 16'h0000 -> 8'h80, 16'h7FFF -> 8'hFF, 16'h8000 -> 8'h00.
- prev_sample updates on every new_sample_ready, in every state.
- Rising crossing: prev_sample[MSB]=1 and sample_in[MSB]=0 on a new_sample_ready cycle.
- States:
  - ARMED: on a strobe with a rising crossing, write that sample at offset 0, set offset=1, go to ACTIVE. Other strobes are not written.
  - ACTIVE: each strobe writes the sample at the current offset and increments offset. The strobe that writes offset 2**ADDR_BITS-1 goes to WAIT with offset=0. No crossing check in this state.
  - WAIT: strobes are not written. When wave_display_idle=1, toggle read_index and go to ARMED. A simultaneous strobe only updates prev_sample.
- Write timing:
  - write_enable pulses exactly one cycle, in the cycle after the accepted strobe.
  - write_address and write_sample are valid in that same cycle and hold their values until the next write.
  - write_enable=0 in every other cycle.
- write_address MSB is ~read_index as seen at strobe time. read_index changes only in WAIT, so a window never straddles halves.
- Back-to-back strobes (every cycle) are supported: one write per cycle, with no drops.
- wave_display_idle is ignored outside WAIT.
- Offset counter is ADDR_BITS wide; it never wraps inside a window. The transition to WAIT ends the window.

Test Plan:
- Reset, then strobe samples 0x0100, 0xFF00, 0x0200 -> write_enable stays 0 for the first two (no crossing; prev_sample resets nonnegative). Third strobe: write_address=256, write_sample=0x82 one cycle later; state=ACTIVE.
- After crossing, strobe 255 further samples (ramp 0x0000, 0x0100, ...), wave_display_idle=0 -> addresses 257..511 written in order, write_enable pulses 256 total. Further strobes produce no writes; read_index stays 0.
- In WAIT, assert wave_display_idle for one cycle -> read_index=1 next cycle. Next crossing writes at address 0; a full window fills addresses 0..255.
- Strobe every cycle through a full window -> 256 consecutive write_enable cycles with contiguous addresses; none dropped.
- Assert reset at offset 100 in ACTIVE -> next cycle write_enable=0, write_address=256, read_index=0. Next write occurs only after a new rising crossing.
- Strobe coinciding with wave_display_idle in WAIT, sample 0x0500 after prev 0xF000 -> read_index toggles, no write. The following strobe 0x0600 causes no trigger, since prev is now nonnegative.
